// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for instruction memory; holds the core in reset until a checksum-verified image is loaded
// Ports: clk, reset (async active-low); start restarts from DONE/ERR;
//   rx_data/rx_valid/rx_ready byte input; wr_en/wr_addr/wr_data memory write port;
//   cpu_hold core reset; done/error load status; words_loaded words written this load.
module imem_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [7:0]  cnt_hi;
    logic [15:0] n;
    logic [15:0] hdr;
    logic [7:0]  xsum;
    logic [23:0] shreg;
    logic [1:0]  bcnt;
    logic [8:0]  widx;
    logic [8:0]  addr_q;
    logic        acc;
    logic        restart;
    assign acc          = rx_valid && rx_ready;
    assign restart      = start && (state == DONE || state == ERR);
    assign hdr          = {cnt_hi, rx_data};
    assign wr_addr      = {23'd0, addr_q};
    assign words_loaded = widx;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= HDR_HI;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            HDR_HI: state_nx = acc ? HDR_LO : HDR_HI;
            HDR_LO: if (acc) state_nx = hdr > 16'(MAX_WORDS) ? ERR : hdr == 16'd0 ? CSUM : DATA;
            // last byte of word N-1 ends the payload
            DATA:   if (acc && bcnt == 2'd3 && {7'd0, widx} == n - 16'd1) state_nx = CSUM;
            CSUM:   if (acc) state_nx = rx_data == xsum ? DONE : ERR;
            DONE:   state_nx = start ? HDR_HI : DONE;
            ERR:    state_nx = start ? HDR_HI : ERR;
            default: state_nx = HDR_HI;
        endcase
    end
    always_comb begin
        rx_ready = state != DONE && state != ERR;
        cpu_hold = state != DONE;
        done     = state == DONE;
        error    = state == ERR;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt_hi  <= '0;
            n       <= '0;
            xsum    <= '0;
            shreg   <= '0;
            bcnt    <= '0;
            widx    <= '0;
            addr_q  <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                xsum <= '0;
                widx <= '0;
                bcnt <= '0;
            end else if (acc) begin
                xsum <= xsum ^ rx_data;
                if (state == HDR_HI) cnt_hi <= rx_data;
                if (state == HDR_LO) n <= hdr;
                if (state == DATA) begin
                    shreg <= {shreg[15:0], rx_data};
                    bcnt  <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        wr_en   <= 1'b1;
                        addr_q  <= widx;
                        wr_data <= {shreg, rx_data};
                        widx    <= widx + 9'd1;
                    end
                end
            end
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frame tests against a frame-level reference model
module tb_imem_loader;
    localparam int MAXW = 256;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, wr_en, cpu_hold, done, error;
    logic [31:0] wr_addr, wr_data;
    logic [8:0]  words_loaded;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  frame[$];
    logic [63:0] obs[$];
    logic [63:0] expw[$];
    logic        exp_done, exp_err;
    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (wr_en) obs.push_back({wr_addr, wr_data});
    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask
    // frame-level model: header count, big-endian words, XOR checksum over all prior bytes
    task automatic model();
        int nw;
        logic [7:0] x;
        expw.delete();
        nw = {frame[0], frame[1]};
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (nw > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        x = frame[0] ^ frame[1];
        for (int i = 0; i < nw; i++) begin
            logic [31:0] w;
            w = '0;
            for (int j = 0; j < 4; j++) begin
                w = (w << 8) | 32'(frame[2 + 4 * i + j]);
                x ^= frame[2 + 4 * i + j];
            end
            expw.push_back({32'(i), w});
        end
        if (frame[2 + 4 * nw] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask
    // gap: 0 back-to-back, 1 idle after every byte, 2 random idles
    task automatic send(input int gap, input int start_at);
        for (int i = 0; i < frame.size(); i++) begin
            @(negedge clk);
            rx_data  = frame[i];
            rx_valid = 1'b1;
            start    = (i == start_at);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                @(negedge clk);
                rx_valid = 1'b0;
                start    = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask
    task automatic run(input string tag, input int gap, input int start_at);
        obs.delete();
        model();
        send(gap, start_at);
        chk({tag, ".nwr"}, 64'(obs.size()), 64'(expw.size()));
        for (int i = 0; i < expw.size(); i++)
            chk({tag, ".wr"}, i < obs.size() ? obs[i] : 64'hx, expw[i]);
        chk({tag, ".done"}, 64'(done), 64'(exp_done));
        chk({tag, ".error"}, 64'(error), 64'(exp_err));
        chk({tag, ".hold"}, 64'(cpu_hold), 64'(!exp_done));
        chk({tag, ".ready"}, 64'(rx_ready), 64'(0));
        chk({tag, ".wl"}, 64'(words_loaded), 64'(expw.size()));
    endtask
    task automatic restart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart.ready", 64'(rx_ready), 64'(1));
        chk("restart.flags", {62'd0, done, error}, 64'(0));
        chk("restart.wl", 64'(words_loaded), 64'(0));
    endtask
    task automatic nominal(input logic [7:0] cs);
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, cs};
    endtask
    task automatic check_reset_vals(input string tag);
        chk({tag, ".ready"}, 64'(rx_ready), 64'(1));
        chk({tag, ".hold"}, 64'(cpu_hold), 64'(1));
        chk({tag, ".wr"}, {31'd0, wr_en, wr_addr}, 64'(0));
        chk({tag, ".wdata"}, 64'(wr_data), 64'(0));
        chk({tag, ".flags"}, {62'd0, done, error}, 64'(0));
        chk({tag, ".wl"}, 64'(words_loaded), 64'(0));
    endtask
    initial begin
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nominal(8'h28);
        run("nominal", 0, -1);
        chk("nominal.w0", obs.size() > 0 ? obs[0] : 64'hx, 64'h00000000_12345678);
        chk("nominal.w1", obs.size() > 1 ? obs[1] : 64'hx, 64'h00000001_DEADBEEF);
        restart();
        nominal(8'h29);
        run("badcsum", 0, -1);
        restart();
        frame = '{8'h01, 8'h01};
        run("oversize", 0, -1);
        restart();
        frame = '{8'h00, 8'h00, 8'h00};
        run("empty", 0, -1);
        restart();
        nominal(8'h28);
        run("throttle", 1, -1);
        restart();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34};
        send(0, -1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;
        nominal(8'h28);
        run("after_rst", 0, -1);
        restart();
        nominal(8'h28);
        run("start_in_data", 0, 5);
        for (int t = 0; t < 12; t++) begin
            int nw;
            logic [7:0] x;
            restart();
            nw = (t == 0) ? MAXW : $urandom_range(0, 9);
            frame = '{8'(nw >> 8), 8'(nw)};
            x = frame[0] ^ frame[1];
            for (int i = 0; i < 4 * nw; i++) begin
                frame.push_back(8'($urandom));
                x ^= frame[$];
            end
            if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
            frame.push_back(x);
            run("random", 2, -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that sits directly upstream of the instruction memory's test write port. It receives a framed program image (header, word payload, checksum) over a valid/ready byte interface and assembles 32-bit words MSB-first. It writes each word into instruction memory at consecutive word addresses and holds the PikaRISC core in reset until a complete, checksum-verified image is loaded.

## Interface

Parameters:
- MAX_WORDS, 256, instruction memory capacity in words; header counts above this are rejected

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; loader state cleared while low
- start  input  1  single-cycle pulse; restarts loading from DONE or ERR, ignored otherwise
- rx_data  input  8  incoming image byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  one-cycle instruction memory write strobe
- wr_addr  output  32  word index being written (0, 1, 2, ...)
- wr_data  output  32  assembled instruction word
- cpu_hold  output  1  drives core reset; high whenever a valid image is not present
- done  output  1  image loaded and checksum matched
- error  output  1  bad header count or checksum mismatch
- words_loaded  output  9  number of words written in the current load

## Operation

- Frame: CNT_HI, CNT_LO (16-bit word count N, MSB first), then 4*N data bytes (each word MSB first), then one CSUM byte.
- CSUM must equal the XOR of every preceding frame byte, header bytes included.
- A byte is accepted on a rising edge with rx_valid && rx_ready. No other event consumes a byte.
- FSM states: HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
  - HDR_HI: accept byte, go to HDR_LO.
  - HDR_LO: accept byte to form N.
    - N > MAX_WORDS → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: shift each byte into a 24-bit assembly register with a 2-bit byte counter. On the 4th byte, register the write (see Timing) and increment the word index. After word N-1 → CSUM.
  - CSUM: accept byte. Equal to running XOR → DONE, otherwise → ERR.
  - DONE: hold. start → HDR_HI.
  - ERR: hold. start → HDR_HI.
- rx_ready = 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in DONE and ERR.
- cpu_hold = 0 only in DONE.
- done = 1 only in DONE. error = 1 only in ERR.
- On entering HDR_HI via start, the following are all cleared: running XOR, word index, byte counter, words_loaded.
- Memory contents from a previous load are not erased.
- start in HDR_HI, HDR_LO, DATA or CSUM is ignored, with no restart.
- words_loaded increments with each wr_en pulse and saturates naturally at MAX_WORDS (9 bits).
- Counts are unsigned. The word index is 9 bits, zero-extended onto wr_addr.

## Timing

- Reset (reset low, asynchronous) forces these values without waiting for clk:
  - state = HDR_HI, rx_ready = 1, cpu_hold = 1
  - wr_en = 0, wr_addr = 0, wr_data = 0
  - done = 0, error = 0, words_loaded = 0
- Reset asserted mid-frame abandons the frame. Loading restarts from HDR_HI once reset deasserts.
- Write timing: if the 4th byte of word k is accepted at edge t, then after edge t:
  - wr_en = 1 for exactly one cycle
  - wr_addr = k
  - wr_data = assembled word
  - wr_en returns to 0 after edge t+1 unless another word completes at t+1, which is impossible because it takes at least 4 bytes.
- rx_ready stays high through write cycles. Back-to-back bytes every cycle are sustained with no stalls.
- State transitions on the accepting edge, e.g. CSUM byte at edge t → done = 1 and cpu_hold = 0 after edge t.
- The last data write and the CSUM acceptance may occur in adjacent cycles. The last wr_en pulse always precedes done.
- rx_valid gaps (rx_valid = 0) leave all state unchanged.

## Test plan

- Nominal load: reset, then send 00 02 12 34 56 78 DE AD BE EF 28 one per cycle. Required response:
  - wr_en pulses with (addr 0, 0x12345678), then (addr 1, 0xDEADBEEF)
  - done = 1, cpu_hold = 0, words_loaded = 2
- Bad checksum: same frame with CSUM 0x29. Required response:
  - both writes occur
  - error = 1, done = 0, cpu_hold = 1, rx_ready = 0
  - start pulse returns to HDR_HI with error = 0
- Oversize header: send 01 01 (N = 257). Required response:
  - ERR after the 2nd byte
  - no wr_en pulses, rx_ready = 0
- Empty image and throttling: send 00 00 00 → done = 1 with no writes. Then start and resend the nominal frame with rx_valid low on alternate cycles → identical writes and result.
- Reset mid-frame: after 00 02 12 34, pull reset low for 1 cycle. Required response:
  - all outputs at reset values immediately
  - resending the full nominal frame yields done = 1 and correct writes at addr 0/1
- start during load: pulse start while in DATA → no effect; the frame completes normally.
